// File: rtl/contador_pkg.sv
// Shared digit limits and widths for the M:DU countdown timer.
package contador_pkg;
    localparam int UNI_MAX_DEF = 9;
    localparam int DEZ_MAX_DEF = 5;
    localparam int MIN_MAX_DEF = 9;
    localparam int UNI_W       = 4;
    localparam int DEZ_W       = 3;
    localparam int MIN_W       = 4;
endpackage

// File: rtl/contador_digito.sv
// One countdown digit: load, decrement request, wrap to MAX with borrow-out.
// Latency 1 clk; no backpressure. Load clamping to MAX under CONTADOR_LOAD_CLAMP_EN.
module contador_digito #(
    parameter int W   = 4,
    parameter int MAX = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_zero,
    output logic         borrow
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] load_eff;

`ifdef CONTADOR_LOAD_CLAMP_EN
    assign load_eff = (load_val > MAX_V) ? MAX_V : load_val;
`else
    assign load_eff = load_val;
`endif

    assign is_zero = (count == '0);
    // Borrow is the decrement request forwarded to the next digit when this one wraps.
    assign borrow  = dec & is_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_eff;
        end else if (dec) begin
            count <= is_zero ? MAX_V : count - W'(1);
        end
    end
endmodule

// File: rtl/contador_nivel2.sv
// M:DU countdown timer built from three chained digits; holds at 0:00, load has priority.
// Latency 1 clk per second step, zero is combinational; no backpressure. Option: CONTADOR_LOAD_CLAMP_EN.
module contador_nivel2
    import contador_pkg::*;
#(
    parameter int UNI_MAX = UNI_MAX_DEF,
    parameter int DEZ_MAX = DEZ_MAX_DEF,
    parameter int MIN_MAX = MIN_MAX_DEF
) (
    input  logic [UNI_W-1:0] uni_sec,
    input  logic [DEZ_W-1:0] dez_sec,
    input  logic [MIN_W-1:0] min,
    input  logic             clk,
    input  logic             enable,
    input  logic             load,
    output logic [UNI_W-1:0] count_us,
    output logic [DEZ_W-1:0] count_ds,
    output logic [MIN_W-1:0] count_m,
    output logic             zero,
    input  logic             rst_n
);
    logic dec_us;
    logic borrow_us, borrow_ds, unused_borrow;
    logic zero_us, zero_ds, zero_m;

    // Gating on zero stops the chain at 0:00, so the minutes digit never wraps.
    assign dec_us = enable & ~load & ~zero;
    assign zero   = zero_us & zero_ds & zero_m;

    contador_digito #(.W(UNI_W), .MAX(UNI_MAX)) u_uni (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (uni_sec),
        .dec      (dec_us),
        .count    (count_us),
        .is_zero  (zero_us),
        .borrow   (borrow_us)
    );

    contador_digito #(.W(DEZ_W), .MAX(DEZ_MAX)) u_dez (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (dez_sec),
        .dec      (borrow_us),
        .count    (count_ds),
        .is_zero  (zero_ds),
        .borrow   (borrow_ds)
    );

    contador_digito #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (min),
        .dec      (borrow_ds),
        .count    (count_m),
        .is_zero  (zero_m),
        .borrow   (unused_borrow)
    );
endmodule

// File: tb/tb_contador_nivel2.sv
// Directed bench with a total-seconds reference model checked every cycle.
module tb_contador_nivel2;
    import contador_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] uni_sec;
    logic [2:0] dez_sec;
    logic [3:0] min;
    logic       enable;
    logic       load;
    logic [3:0] count_us;
    logic [2:0] count_ds;
    logic [3:0] count_m;
    logic       zero;

    int checks = 0;
    int errors = 0;
    int mt;
    bit chk_en = 1'b0;

    localparam int US = UNI_MAX_DEF + 1;
    localparam int DS = DEZ_MAX_DEF + 1;

    contador_nivel2 dut (
        .uni_sec  (uni_sec),
        .dez_sec  (dez_sec),
        .min      (min),
        .clk      (clk),
        .enable   (enable),
        .load     (load),
        .count_us (count_us),
        .count_ds (count_ds),
        .count_m  (count_m),
        .zero     (zero),
        .rst_n    (rst_n)
    );

    always #5 clk = ~clk;

    function automatic int to_sec(int m, int d, int u);
        return m * US * DS + d * US + u;
    endfunction

    // Reference: the timer is a number of seconds that counts down and stops at 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  mt <= 0;
        else if (load)               mt <= to_sec(int'(min), int'(dez_sec), int'(uni_sec));
        else if (enable && mt > 0)   mt <= mt - 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int eu, ed, em;
            bit ez;
            eu = mt % US;
            ed = (mt / US) % DS;
            em = mt / (US * DS);
            ez = (mt == 0);
            checks++;
            if (int'(count_m) != em || int'(count_ds) != ed || int'(count_us) != eu || zero !== ez) begin
                errors++;
                $display("FAIL model t=%0t got %0d:%0d%0d zero=%0b required %0d:%0d%0d zero=%0b",
                         $time, count_m, count_ds, count_us, zero, em, ed, eu, ez);
            end
        end
    end

    task automatic edge1();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_v(string nm, int m, int d, int u, bit z);
        checks++;
        if (int'(count_m) != m || int'(count_ds) != d || int'(count_us) != u || zero !== z) begin
            errors++;
            $display("FAIL %s got %0d:%0d%0d zero=%0b required %0d:%0d%0d zero=%0b",
                     nm, count_m, count_ds, count_us, zero, m, d, u, z);
        end
    endtask

    task automatic do_load(int m, int d, int u);
        min     = 4'(m);
        dez_sec = 3'(d);
        uni_sec = 4'(u);
        load    = 1'b1;
        edge1();
        load    = 1'b0;
    endtask

    initial begin
        int clamp_u;
        rst_n   = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        min     = '0;
        dez_sec = '0;
        uni_sec = '0;
        #12;
        expect_v("reset", 0, 0, 0, 1'b1);
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // First edge after release is a load, with enable already high.
        enable = 1'b1;
        do_load(8, 5, 7);
        expect_v("load_857", 8, 5, 7, 1'b0);
        edge1(); expect_v("dec_856", 8, 5, 6, 1'b0);
        edge1(); expect_v("dec_855", 8, 5, 5, 1'b0);
        edge1(); expect_v("dec_854", 8, 5, 4, 1'b0);
        edge1(); expect_v("dec_853", 8, 5, 3, 1'b0);

        do_load(1, 0, 0);
        expect_v("load_100", 1, 0, 0, 1'b0);
        edge1(); expect_v("borrow_059", 0, 5, 9, 1'b0);
        edge1(); expect_v("dec_058", 0, 5, 8, 1'b0);

        do_load(0, 0, 2);
        edge1(); expect_v("dec_001", 0, 0, 1, 1'b0);
        edge1(); expect_v("reach_000", 0, 0, 0, 1'b1);
        edge1(); expect_v("hold_000", 0, 0, 0, 1'b1);

        do_load(0, 1, 0);
        edge1(); expect_v("tens_borrow_009", 0, 0, 9, 1'b0);

        enable = 1'b0;
        do_load(3, 3, 0);
        expect_v("load_330", 3, 3, 0, 1'b0);
        repeat (5) edge1();
        expect_v("hold_disabled", 3, 3, 0, 1'b0);
        enable = 1'b1;
        load   = 1'b1;
        edge1();
        load   = 1'b0;
        expect_v("load_priority", 3, 3, 0, 1'b0);

        do_load(2, 1, 0);
        edge1(); expect_v("dec_209", 2, 0, 9, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_v("async_reset", 0, 0, 0, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        edge1(); expect_v("post_reset_hold1", 0, 0, 0, 1'b1);
        edge1(); expect_v("post_reset_hold2", 0, 0, 0, 1'b1);

        do_load(2, 0, 5);
        repeat (130) edge1();
        expect_v("long_run_end", 0, 0, 0, 1'b1);

        // Out-of-range units digit; the reference model only covers in-range values.
        chk_en = 1'b0;
        enable = 1'b0;
`ifdef CONTADOR_LOAD_CLAMP_EN
        clamp_u = 9;
`else
        clamp_u = 15;
`endif
        do_load(0, 0, 15);
        expect_v("load_uni15", 0, 0, clamp_u, 1'b0);
        enable = 1'b1;
        edge1();
        expect_v("dec_uni15", 0, 0, clamp_u - 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/contador_nivel2.md
CONTADOR_NIVEL2 -- requirements
Module: contador_nivel2

Interface
- REQ-001 SHALL have parameter UNI_MAX, default 9: maximum value of the seconds-units digit.
- REQ-002 SHALL have parameter DEZ_MAX, default 5: maximum value of the seconds-tens digit.
- REQ-003 SHALL have parameter MIN_MAX, default 9: maximum value of the minutes digit.
- REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-006 SHALL have port uni_sec, input, 4 bits: load value for the seconds units.
- REQ-007 SHALL have port dez_sec, input, 3 bits: load value for the seconds tens.
- REQ-008 SHALL have port min, input, 4 bits: load value for the minutes.
- REQ-009 SHALL have port enable, input, 1 bit: count-down enable.
- REQ-010 SHALL have port load, input, 1 bit: synchronous preset of all three digits.
- REQ-011 SHALL have port count_us, output, 4 bits: current seconds-units digit.
- REQ-012 SHALL have port count_ds, output, 3 bits: current seconds-tens digit.
- REQ-013 SHALL have port count_m, output, 4 bits: current minutes digit.
- REQ-014 SHALL have port zero, output, 1 bit: high when the counter reads 0:00.
- REQ-015 SHALL be connected by name; positional order is uni_sec, dez_sec, min, clk, enable, load, count_us, count_ds, count_m, zero, rst_n.

Function
- REQ-016 SHALL, when load=1 at a rising edge, copy uni_sec, dez_sec and min into the three count registers, regardless of enable.
- REQ-017 SHALL give load priority over counting; a load edge never decrements.
- REQ-018 SHALL, when load=0, enable=1 and zero=0, decrement the M:DU value by one second per rising edge.
- REQ-019 SHALL decrement count_us when count_us≠0.
- REQ-020 SHALL, when count_us=0, set count_us to UNI_MAX and decrement count_ds.
- REQ-021 SHALL, when count_us=0 and count_ds=0, set count_ds to DEZ_MAX and decrement count_m.
- REQ-022 SHALL hold all registers when enable=0 and load=0.
- REQ-023 SHALL hold at 0:00 once reached, with no wrap to 9:59, even with enable=1.
- REQ-024 SHALL drive zero combinationally: zero=1 exactly when count_us=0, count_ds=0 and count_m=0, asserted in the same cycle the registers reach 0:00.
- REQ-025 SHALL leave count_m at 0 during a tens borrow from 0:x0; the borrow cases are mutually exclusive with the zero state.

Reset
- REQ-026 SHALL, when rst_n=0, immediately clear count_us, count_ds and count_m to 0, giving zero=1, independent of clk.
- REQ-027 SHALL, on a reset asserted mid-count, abort the count; after release, the counter stays at 0:00 until a load.
- REQ-028 SHALL treat the first rising edge after rst_n deasserts as a normal edge (load or count).

Configuration
- REQ-029 SHALL, with macro CONTADOR_LOAD_CLAMP_EN defined, clamp loaded digits above UNI_MAX, DEZ_MAX or MIN_MAX to that maximum (e.g. uni_sec=15 loads 9).
- REQ-030 SHALL, without macro CONTADOR_LOAD_CLAMP_EN, load digits verbatim; an out-of-range digit then decrements normally toward 0 (15→14→…).

Structure
- REQ-031 SHALL place UNI_MAX, DEZ_MAX and MIN_MAX defaults and the digit widths (4, 3, 4) in shared package contador_pkg.
- REQ-032 SHALL implement each digit in one sub-module, contador_digito (parameterised width and max, with load, decrement-request and borrow-out), instantiated three times and chained by borrow.

Verification
- REQ-033 SHALL cover: rst_n=0, then load 8:57 (min=8, dez=5, uni=7) with enable=1, then 4 enabled edges → 8:57, 8:56, 8:55, 8:54, 8:53, zero=0.
- REQ-034 SHALL cover: load 1:00 then 1 enabled edge → 0:59; next edge → 0:58.
- REQ-035 SHALL cover: load 0:02 then 3 enabled edges → 0:01, 0:00 (zero=1), 0:00 held.
- REQ-036 SHALL cover: load 3:30 with enable=0 for 5 edges → held at 3:30; load and enable both 1 → load wins, value 3:30.
- REQ-037 SHALL cover: counting from 2:10, pull rst_n low between edges → outputs 0:00 and zero=1 immediately, before the next clk edge.
- REQ-038 SHALL cover: uni_sec=15 loaded → 9 with CONTADOR_LOAD_CLAMP_EN defined, 15 without it.
